// File: rtl/elevator_pkg.sv
// Shared widths and the SCAN direction state type for the elevator scheduler.
package elevator_pkg;

  localparam int unsigned FLOOR_W    = 4;
  localparam int unsigned MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } sched_state_t;

endpackage

// File: rtl/floor_scan_select.sv
// Combinational nearest-call search above and below the car position.
// The above search includes cur_floor except in IDLE, where only strictly
// higher calls count; the below search always includes cur_floor.
module floor_scan_select
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 10
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  sched_state_t          direction,
  output logic                  found_above,
  output logic                  found_below,
  output logic [FLOOR_W-1:0]    nearest_above,
  output logic [FLOOR_W-1:0]    nearest_below
);

  // Two priority scans; the last hit in each loop is the closest call.
  always_comb begin
    found_above   = 1'b0;
    found_below   = 1'b0;
    nearest_above = '0;
    nearest_below = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && ((i > int'(cur_floor)) ||
                         ((direction != IDLE) && (i == int'(cur_floor))))) begin
        found_above   = 1'b1;
        nearest_above = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (i <= int'(cur_floor))) begin
        found_below   = 1'b1;
        nearest_below = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: captures calls into a pending bitmap, runs the
// SCAN direction FSM and presents one registered target floor.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrive,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  busy,
  output logic [NUM_FLOORS-1:0] pending
);

  logic [FLOOR_W-1:0]    cur_sat;
  logic                  req_valid_q, req_edge_q, arrive_q;
  logic [FLOOR_W-1:0]    req_floor_q, arr_floor_q;
  logic                  req_accept;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  sched_state_t          state_q, state_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  target_valid_q, target_valid_d;
  logic                  found_above, found_below;
  logic [FLOOR_W-1:0]    nearest_above, nearest_below;

  // Out-of-range car positions are treated as the top floor.
  always_comb begin
    cur_sat = (32'(cur_floor) >= NUM_FLOORS) ? FLOOR_W'(NUM_FLOORS - 1) : cur_floor;
  end

  // Input stage: request edge detect plus arrive pulse, both with their floor.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      req_valid_q <= 1'b0;
      req_edge_q  <= 1'b0;
      req_floor_q <= '0;
      arrive_q    <= 1'b0;
      arr_floor_q <= '0;
    end else begin
      req_valid_q <= req_valid;
      req_edge_q  <= req_valid & ~req_valid_q;
      req_floor_q <= req_floor;
      arrive_q    <= arrive;
      arr_floor_q <= cur_sat;
    end
  end

  // Pending update; a clear for the served floor overrides a same-cycle set.
  always_comb begin
    req_accept = req_edge_q && (32'(req_floor_q) < NUM_FLOORS) &&
                 !((state_q == IDLE) && (req_floor_q == cur_sat));
    pending_d  = pending_q;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (req_accept && (32'(req_floor_q) == i)) pending_d[i] = 1'b1;
      if (arrive_q && (32'(arr_floor_q) == i)) pending_d[i] = 1'b0;
    end
  end

  floor_scan_select #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_scan (
    .pending       (pending_q),
    .cur_floor     (cur_sat),
    .direction     (state_q),
    .found_above   (found_above),
    .found_below   (found_below),
    .nearest_above (nearest_above),
    .nearest_below (nearest_below)
  );

  // SCAN direction FSM; the target follows the direction being entered so a
  // reversal picks the first call on the new side in the same update.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    target_valid_d = |pending_q;
    unique case (state_q)
      IDLE: begin
        if (found_above)     state_d = UP;
        else if (|pending_q) state_d = DOWN;
      end
      UP: begin
        if (!(|pending_q))    state_d = IDLE;
        else if (!found_above) state_d = DOWN;
      end
      DOWN: begin
        if (!(|pending_q))    state_d = IDLE;
        else if (!found_below) state_d = UP;
      end
      default: state_d = IDLE;
    endcase
    if (|pending_q) begin
      target_d = (state_d == UP) ? nearest_above : nearest_below;
    end
  end

  // Pending map, direction state and registered target.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q      <= '0;
      state_q        <= IDLE;
      target_q       <= '0;
      target_valid_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      state_q        <= state_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
    end
  end

  assign pending      = pending_q;
  assign target_floor = target_q;
  assign target_valid = target_valid_q;
  assign dir_up       = (state_q == UP);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed, table-driven bench for elevator_request_scheduler (NUM_FLOORS=10).
module tb_elevator_request_scheduler;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [3:0] req_floor;
  logic       req_valid;
  logic [3:0] cur_floor;
  logic       arrive;
  logic [3:0] target_floor;
  logic       target_valid;
  logic       dir_up;
  logic       busy;
  logic [9:0] pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cur;
    logic [3:0] rf;
    logic       rq;
    logic       ar;
    logic [9:0] p;
    logic [3:0] t;
    logic       tv;
    logic       up;
    logic       bz;
  } vec_t;

  vec_t vecs [24];

  elevator_request_scheduler #(
    .NUM_FLOORS (10)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .req_floor    (req_floor),
    .req_valid    (req_valid),
    .cur_floor    (cur_floor),
    .arrive       (arrive),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .busy         (busy),
    .pending      (pending)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] p, input logic [3:0] t,
                           input logic tv, input logic up, input logic bz);
    check({tag, " pending"}, 32'(pending), 32'(p));
    check({tag, " target_floor"}, 32'(target_floor), 32'(t));
    check({tag, " target_valid"}, 32'(target_valid), 32'(tv));
    check({tag, " dir_up"}, 32'(dir_up), 32'(up));
    check({tag, " busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    //          cur  rf    rq ar  pending  tgt  tv up bz
    vecs[0]  = '{4'd0, 4'd7, 1, 0, 10'h080, 4'd7, 1, 1, 1};
    vecs[1]  = '{4'd2, 4'd4, 1, 0, 10'h090, 4'd4, 1, 1, 1};  // pickup ahead
    vecs[2]  = '{4'd4, 4'd0, 0, 1, 10'h080, 4'd7, 1, 1, 1};
    vecs[3]  = '{4'd4, 4'd3, 1, 0, 10'h088, 4'd7, 1, 1, 1};
    vecs[4]  = '{4'd6, 4'd6, 1, 0, 10'h0C8, 4'd6, 1, 1, 1};
    vecs[5]  = '{4'd6, 4'd0, 0, 1, 10'h088, 4'd7, 1, 1, 1};
    vecs[6]  = '{4'd7, 4'd0, 0, 1, 10'h008, 4'd3, 1, 0, 1};  // reverse to DOWN
    vecs[7]  = '{4'd5, 4'd1, 1, 0, 10'h00A, 4'd3, 1, 0, 1};
    vecs[8]  = '{4'd4, 4'd2, 1, 0, 10'h00E, 4'd3, 1, 0, 1};
    vecs[9]  = '{4'd3, 4'd0, 0, 1, 10'h006, 4'd2, 1, 0, 1};
    vecs[10] = '{4'd3, 4'd9, 1, 0, 10'h206, 4'd2, 1, 0, 1};  // behind: no pickup
    vecs[11] = '{4'd2, 4'd0, 0, 1, 10'h202, 4'd1, 1, 0, 1};
    vecs[12] = '{4'd1, 4'd0, 0, 1, 10'h200, 4'd9, 1, 1, 1};  // reverse to UP
    vecs[13] = '{4'd9, 4'd0, 0, 1, 10'h000, 4'd9, 0, 0, 0};  // empty: IDLE, target holds
    vecs[14] = '{4'd3, 4'd3, 1, 0, 10'h000, 4'd9, 0, 0, 0};  // IDLE at own floor
    vecs[15] = '{4'd3, 4'd12, 1, 0, 10'h000, 4'd9, 0, 0, 0}; // out of range
    vecs[16] = '{4'd3, 4'd15, 1, 0, 10'h000, 4'd9, 0, 0, 0};
    vecs[17] = '{4'd3, 4'd8, 1, 0, 10'h100, 4'd8, 1, 1, 1};
    vecs[18] = '{4'd4, 4'd4, 1, 0, 10'h110, 4'd4, 1, 1, 1};
    vecs[19] = '{4'd4, 4'd4, 1, 1, 10'h100, 4'd8, 1, 1, 1};  // clear beats set
    vecs[20] = '{4'd4, 4'd4, 1, 1, 10'h100, 4'd8, 1, 1, 1};
    vecs[21] = '{4'd4, 4'd2, 1, 1, 10'h104, 4'd8, 1, 1, 1};  // other floor still set
    vecs[22] = '{4'd12, 4'd9, 1, 0, 10'h304, 4'd9, 1, 0, 1}; // cur saturates to 9
    vecs[23] = '{4'd12, 4'd0, 0, 1, 10'h104, 4'd8, 1, 0, 1}; // arrive clears bit 9

    RESET_N   = 1'b0;
    req_floor = '0;
    req_valid = 1'b0;
    cur_floor = '0;
    arrive    = 1'b0;
    tick();
    tick();
    check_all("reset", 10'h000, 4'd0, 0, 0, 0);
    RESET_N = 1'b1;
    check_all("post_release", 10'h000, 4'd0, 0, 0, 0);

    // Latency: bit after edge N+1, target after edge N+2.
    req_floor = 4'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lat N pending", 32'(pending), 32'h000);
    tick();
    check("lat N+1 pending", 32'(pending), 32'h020);
    check("lat N+1 target_valid", 32'(target_valid), 32'h0);
    tick();
    check_all("lat N+2", 10'h020, 4'd5, 1, 1, 1);

    // Serve floor 5 to return to IDLE before the table.
    cur_floor = 4'd5;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    check("arr N+1 pending", 32'(pending), 32'h000);
    check("arr N+1 busy", 32'(busy), 32'h1);
    tick();
    check_all("arr N+2", 10'h000, 4'd5, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cur_floor = vecs[i].cur;
      req_floor = vecs[i].rf;
      req_valid = vecs[i].rq;
      arrive    = vecs[i].ar;
      tick();
      req_valid = 1'b0;
      arrive    = 1'b0;
      tick();
      tick();
      check_all($sformatf("v%0d", i), vecs[i].p, vecs[i].t, vecs[i].tv, vecs[i].up,
                vecs[i].bz);
    end

    // Asynchronous reset mid-travel, away from a clock edge.
    check("pre_reset pending", 32'(pending), 32'h104);
    cur_floor = 4'd0;
    req_floor = 4'd6;
    req_valid = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    check_all("async_reset", 10'h000, 4'd0, 0, 0, 0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check("rel N pending", 32'(pending), 32'h000);
    tick();
    check("rel N+1 pending", 32'(pending), 32'h040);
    tick();
    check_all("rel N+2", 10'h040, 4'd6, 1, 1, 1);

    // req_valid still high: serving the call must not re-capture it.
    cur_floor = 4'd6;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    tick();
    check_all("rel served", 10'h000, 4'd6, 0, 0, 0);
    tick();
    tick();
    tick();
    check("rel no recapture", 32'(pending), 32'h000);
    req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
